// File: rtl/bbtron_pkg.sv
// Shared BBtron definitions: output-buffer FSM encoding and default sizing.
package bbtron_pkg;

   localparam int unsigned OB_DATA_W      = 33;
   localparam int unsigned OB_DEPTH       = 4;
   localparam int unsigned OB_HOLD_CYCLES = 50_000_000;

   typedef enum logic {
      OB_IDLE = 1'b0,
      OB_SHOW = 1'b1
   } ob_state_t;

   function automatic int unsigned ob_count_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/outbuf_fifo.sv
// Synchronous FIFO for the output-port buffer; head word visible on dout.
module outbuf_fifo
   import bbtron_pkg::*;
#(
   parameter int unsigned DATA_W = OB_DATA_W,
   parameter int unsigned DEPTH  = OB_DEPTH
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    push,
   input  logic                    pop,
   input  logic [DATA_W-1:0]       din,
   output logic [DATA_W-1:0]       dout,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic              do_push;
   logic              do_pop;

   // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
   assign full    = (count == FULL_CNT);
   assign do_push = push && !full;
   assign do_pop  = pop && (count != '0);
   assign dout    = mem[rptr];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wptr] <= din;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + 1'b1;
         end
         if (do_pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/out_port_buffer.sv
// BBtron OUT-port buffer: queues core writes and holds each on the display for HOLD_CYCLES.
// Define OUTBUF_OVERFLOW_EN to build sticky detection of writes dropped while full.
module out_port_buffer
   import bbtron_pkg::*;
#(
   parameter int unsigned DATA_W      = OB_DATA_W,
   parameter int unsigned DEPTH       = OB_DEPTH,
   parameter int unsigned HOLD_CYCLES = OB_HOLD_CYCLES
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    out_en,
   input  logic [DATA_W-1:0]       out_data,
   output logic                    out_full,
   output logic [DATA_W-1:0]       disp_value,
   output logic                    disp_valid,
   output logic [$clog2(DEPTH):0]  fifo_count,
   output logic                    overflow
);

   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

   ob_state_t         state;
   logic [HW-1:0]     hold_cnt;
   logic              pop;
   logic [DATA_W-1:0] head;

   outbuf_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (out_en),
      .pop   (pop),
      .din   (out_data),
      .dout  (head),
      .count (fifo_count),
      .full  (out_full)
   );

   always_comb begin
      pop = 1'b0;
      unique case (state)
         OB_IDLE: pop = (fifo_count != '0);
         OB_SHOW: pop = (hold_cnt == '0) && (fifo_count != '0);
         default: pop = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= OB_IDLE;
         hold_cnt   <= '0;
         disp_value <= '0;
         disp_valid <= 1'b0;
      end else begin
         unique case (state)
            OB_IDLE: begin
               if (pop) begin
                  disp_value <= head;
                  disp_valid <= 1'b1;
                  hold_cnt   <= HOLD_LOAD;
                  state      <= OB_SHOW;
               end
            end
            OB_SHOW: begin
               if (hold_cnt != '0) begin
                  hold_cnt <= hold_cnt - 1'b1;
               end else if (pop) begin
                  disp_value <= head;
                  hold_cnt   <= HOLD_LOAD;
               end else begin
                  state <= OB_IDLE;
               end
            end
            default: state <= OB_IDLE;
         endcase
      end
   end

`ifdef OUTBUF_OVERFLOW_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (out_en && out_full) begin
         overflow <= 1'b1;
      end
   end
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_out_port_buffer.sv
// Scoreboard bench for out_port_buffer with DEPTH=2, HOLD_CYCLES=4.
module tb_out_port_buffer;
   import bbtron_pkg::*;

   localparam int unsigned DW   = 33;
   localparam int unsigned DEP  = 2;
   localparam int unsigned HOLD = 4;

`ifdef OUTBUF_OVERFLOW_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          out_en = 1'b0;
   logic [DW-1:0] out_data = '0;
   logic          out_full;
   logic [DW-1:0] disp_value;
   logic          disp_valid;
   logic [1:0]    fifo_count;
   logic          overflow;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] exp_q[$];

   out_port_buffer #(
      .DATA_W      (DW),
      .DEPTH       (DEP),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .out_en     (out_en),
      .out_data   (out_data),
      .out_full   (out_full),
      .disp_value (disp_value),
      .disp_valid (disp_valid),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every new displayed word must be the next queued write, after a full hold.
   logic [DW-1:0] prev_value = '0;
   logic          prev_valid = 1'b0;
   int            run = 0;

   always @(negedge clock) begin
      if (reset) begin
         prev_valid = 1'b0;
         run = 0;
      end else begin
         if (disp_valid && (!prev_valid || disp_value != prev_value)) begin
            if (prev_valid) chk("hold_len", 64'(run >= HOLD), 64'd1);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL disp_seq actual=%0h required=nothing_queued", disp_value);
            end else begin
               chk("disp_seq", disp_value, exp_q.pop_front());
            end
            prev_value = disp_value;
            run = 1;
         end else begin
            run++;
         end
         prev_valid = disp_valid;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      out_en = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic write(input logic [DW-1:0] v);
      out_en   = 1'b1;
      out_data = v;
      exp_q.push_back(v);
      tick();
      out_en = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_disp_value"}, disp_value, 0);
      chk({tag, "_disp_valid"}, disp_valid, 0);
      chk({tag, "_count"}, fifo_count, 0);
      chk({tag, "_full"}, out_full, 0);
      chk({tag, "_overflow"}, overflow, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] v;
      logic [DW-1:0] last;
      int budget;

      // Reset, no writes
      do_reset();
      for (int i = 0; i < 4; i++) begin
         repeat (5) tick();
         chk_reset_vals("idle");
      end

      // Single write: visible one edge after capture, then held indefinitely
      write(33'h2A);
      chk("single_count", fifo_count, 1);
      chk("single_valid_early", disp_valid, 0);
      tick();
      chk("single_disp", disp_value, 33'h2A);
      chk("single_valid", disp_valid, 1);
      chk("single_count0", fifo_count, 0);
      repeat (4) tick();
      chk("single_idle", dut.state, OB_IDLE);
      repeat (100) tick();
      chk("single_persist", disp_value, 33'h2A);
      chk("single_persist_valid", disp_valid, 1);

      // 5,6,7 back to back: the first pops immediately, so all three fit
      do_reset();
      write(33'd5);
      write(33'd6);
      chk("b2b_disp5", disp_value, 5);
      write(33'd7);
      chk("b2b_full", out_full, 1);
      chk("b2b_count", fifo_count, 2);
      repeat (2) tick();
      chk("b2b_disp5_end", disp_value, 5);
      tick();
      chk("b2b_disp6", disp_value, 6);
      chk("b2b_full_clear", out_full, 0);
      repeat (3) tick();
      chk("b2b_disp6_end", disp_value, 6);
      tick();
      chk("b2b_disp7", disp_value, 7);
      chk("b2b_count_end", fifo_count, 0);
      chk("b2b_overflow", overflow, 0);

      // Push while full coinciding with an internal pop: rejected
      do_reset();
      write(33'h11);
      write(33'h22);
      write(33'h33);
      repeat (2) tick();
      chk("fullpop_pre_full", out_full, 1);
      out_en   = 1'b1;
      out_data = 33'hDD;
      tick();
      out_en = 1'b0;
      chk("fullpop_count", fifo_count, 1);
      chk("fullpop_full", out_full, 0);
      chk("fullpop_disp", disp_value, 33'h22);
      chk("fullpop_overflow", overflow, OVF_EXP);
      repeat (10) tick();
      chk("fullpop_last", disp_value, 33'h33);
      chk("fullpop_overflow_sticky", overflow, OVF_EXP);

      // Reset mid-SHOW with two entries queued
      do_reset();
      write(33'h41);
      write(33'h42);
      write(33'h43);
      chk("midrst_pre_count", fifo_count, 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      chk_reset_vals("midrst");
      write(33'd9);
      chk("midrst_w9_early", disp_value, 0);
      tick();
      chk("midrst_w9", disp_value, 9);
      chk("midrst_w9_valid", disp_valid, 1);

      // 64 random writes honoring out_full
      last = 33'd9;
      for (int i = 0; i < 64; i++) begin
         do begin
            v = {1'($urandom), 32'($urandom)};
         end while (v == last);
         last = v;
         budget = 0;
         while (out_full && budget < 100) begin
            tick();
            budget++;
         end
         if (budget >= 100) chk("rand_stall_timeout", 1, 0);
         write(v);
      end
      budget = 0;
      while (exp_q.size() != 0 && budget < 2000) begin
         tick();
         budget++;
      end
      chk("rand_drained", exp_q.size(), 0);
      repeat (6) tick();
      chk("rand_last", disp_value, last);
      chk("rand_count", fifo_count, 0);
      chk("rand_overflow", overflow, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
